// File: rtl/bridge_arb_pkg.sv
`default_nettype none
//==============================================================================
// Module      : bridge_arb_pkg
// Description : Shared types and helpers for the bridge request arbiter.
//               Provides the requester-ID type, the request/response FSM
//               state encodings, and the round-robin pick function.
// Revision    : 1.0 - initial release
//==============================================================================
`ifndef MERGED_REQUEST_WIDTH
`define MERGED_REQUEST_WIDTH 8
`endif

package bridge_arb_pkg;

    // Upper bound on requesters; the ID type is sized for it so one package
    // serves every legal N_REQ (2..8).
    localparam int c_MAX_REQ  = 8;
    localparam int c_MAX_ID_W = 3;

    typedef logic [c_MAX_ID_W-1:0] req_id_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_SEND = 1'b1
    } req_state_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } resp_state_t;

    // One-hot grant: first set bit of req_vec at or above ptr, wrapping at n.
    // The loop walks from the farthest candidate to the nearest so the last
    // hit (nearest to ptr) wins.
    function automatic logic [c_MAX_REQ-1:0] rr_pick(
        input logic [c_MAX_REQ-1:0] req_vec,
        input req_id_t              ptr,
        input int                   n
    );
        logic [c_MAX_REQ-1:0] grant;
        int                   idx;
        grant = '0;
        for (int k = c_MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                if (req_vec[idx[2:0]]) begin
                    grant = 8'b1 << idx[2:0];
                end
            end
        end
        return grant;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bridge_id_fifo.sv
`default_nettype none
//==============================================================================
// Module      : bridge_id_fifo
// Description : Outstanding-ID FIFO. Records which requester owns each
//               request in flight so responses can be routed back in order.
// Ports       : clk, res_n (sync active-low), push/push_id, pop/head_id,
//               full, empty.
// Revision    : 1.0 - initial release
//==============================================================================
module bridge_id_fifo #(
    parameter int DEPTH = 4,   // power of two
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_id,
    input  logic             pop,
    output logic [WIDTH-1:0] head_id,
    output logic             full,
    output logic             empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= push_id;
    end

    assign head_id = r_mem[r_rd_ptr];
    assign full    = (r_count == c_CNT_W'(DEPTH));
    assign empty   = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/bridge_req_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : bridge_req_arbiter
// Description : Shares one flit-buffer bridge-master port among N_REQ local
//               requesters. Round-robin request grant with a registered
//               request toward the buffer; in-order responses routed back
//               via an outstanding-ID FIFO.
// Ports       : clk, res_n (sync active-low)
//               req_avail/req_taken/req_data         - requester side
//               data_from_bridge_*/merged_request_bridge_to_buffer - to buffer
//               data_to_bridge_*/merged_request_buffer_to_bridge   - from buffer
//               resp_avail/resp_taken/resp_data      - response to requesters
//               err_orphan                           - sticky orphan response
// Revision    : 1.0 - initial release
//==============================================================================
`ifndef MERGED_REQUEST_WIDTH
`define MERGED_REQUEST_WIDTH 8
`endif

module bridge_req_arbiter
    import bridge_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int REQ_W     = `MERGED_REQUEST_WIDTH,
    parameter int MAX_OUTST = 4
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic [N_REQ-1:0]   req_avail,
    output logic [N_REQ-1:0]   req_taken,
    input  logic [N_REQ*REQ_W-1:0] req_data,
    output logic               data_from_bridge_avail,
    input  logic               data_from_bridge_taken,
    output logic [REQ_W-1:0]   merged_request_bridge_to_buffer,
    input  logic               data_to_bridge_avail,
    output logic               data_to_bridge_taken,
    input  logic [REQ_W-1:0]   merged_request_buffer_to_bridge,
    output logic [N_REQ-1:0]   resp_avail,
    input  logic [N_REQ-1:0]   resp_taken,
    output logic [REQ_W-1:0]   resp_data,
    output logic               err_orphan
);

    localparam int ID_W = $clog2(N_REQ);

    req_state_t          r_req_state, w_req_state_nxt;
    resp_state_t         r_resp_state, w_resp_state_nxt;
    logic [ID_W-1:0]     r_rr_ptr, r_grant_id, r_resp_id;
    logic [ID_W-1:0]     w_grant_id, w_head_id;
    logic [REQ_W-1:0]    r_req_data, r_resp_data;
    logic                r_err_orphan;
    logic [c_MAX_REQ-1:0] w_req_ext, w_pick;
    req_id_t             w_ptr_ext;
    logic [N_REQ-1:0]    w_grant_vec, w_resp_onehot;
    logic                w_grant_fire, w_resp_fire, w_pop, w_orphan;
    logic                w_fifo_full, w_fifo_empty;

    // Round-robin pick on zero-extended vectors, then encode to an index.
    always_comb begin
        w_req_ext               = '0;
        w_req_ext[N_REQ-1:0]    = req_avail;
        w_ptr_ext               = '0;
        w_ptr_ext[ID_W-1:0]     = r_rr_ptr;
        w_pick                  = rr_pick(w_req_ext, w_ptr_ext, N_REQ);
        w_grant_vec             = w_pick[N_REQ-1:0];
        w_grant_id              = '0;
        for (int i = 0; i < c_MAX_REQ; i++) begin
            if (w_pick[i]) w_grant_id = ID_W'(i);
        end
    end

    //--------------------------------------------------------------------------
    // Request FSM. Full check uses the registered FIFO count, so a pop in the
    // same cycle does not open a grant. Pulses are suppressed during reset.
    //--------------------------------------------------------------------------
    always_comb begin
        w_req_state_nxt = r_req_state;
        w_grant_fire    = 1'b0;
        req_taken       = '0;
        case (r_req_state)
            R_IDLE: begin
                if (res_n && (|req_avail) && !w_fifo_full) begin
                    w_grant_fire    = 1'b1;
                    req_taken       = w_grant_vec;
                    w_req_state_nxt = R_SEND;
                end
            end
            R_SEND: begin
                if (data_from_bridge_taken) w_req_state_nxt = R_IDLE;
            end
            default: w_req_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_req_state <= R_IDLE;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_req_data  <= '0;
        end else begin
            r_req_state <= w_req_state_nxt;
            if (w_grant_fire) begin
                r_grant_id <= w_grant_id;
                r_req_data <= req_data[int'(w_grant_id)*REQ_W +: REQ_W];
            end
            // Pointer moves past the winner only once the buffer accepts.
            if ((r_req_state == R_SEND) && data_from_bridge_taken) begin
                r_rr_ptr <= (r_grant_id == ID_W'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;
            end
        end
    end

    assign data_from_bridge_avail          = (r_req_state == R_SEND);
    assign merged_request_bridge_to_buffer = r_req_data;

    //--------------------------------------------------------------------------
    // Response FSM. A response with no outstanding ID is left in the buffer
    // and flagged; it is never consumed.
    //--------------------------------------------------------------------------
    assign w_resp_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_resp_id;

    always_comb begin
        w_resp_state_nxt     = r_resp_state;
        data_to_bridge_taken = 1'b0;
        w_resp_fire          = 1'b0;
        w_orphan             = 1'b0;
        w_pop                = 1'b0;
        resp_avail           = '0;
        case (r_resp_state)
            S_IDLE: begin
                if (res_n && data_to_bridge_avail) begin
                    if (!w_fifo_empty) begin
                        w_resp_fire          = 1'b1;
                        data_to_bridge_taken = 1'b1;
                        w_resp_state_nxt     = S_HOLD;
                    end else begin
                        w_orphan = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                resp_avail = w_resp_onehot;
                // Only the owning requester can retire the response.
                if (resp_taken[r_resp_id]) begin
                    w_pop            = 1'b1;
                    w_resp_state_nxt = S_IDLE;
                end
            end
            default: w_resp_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_resp_state <= S_IDLE;
            r_resp_id    <= '0;
            r_resp_data  <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            r_resp_state <= w_resp_state_nxt;
            if (w_resp_fire) begin
                r_resp_id   <= w_head_id;
                r_resp_data <= merged_request_buffer_to_bridge;
            end
            if (w_orphan) r_err_orphan <= 1'b1;
        end
    end

    assign resp_data  = r_resp_data;
    assign err_orphan = r_err_orphan;

    bridge_id_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (ID_W)
    ) u_id_fifo (
        .clk     (clk),
        .res_n   (res_n),
        .push    (w_grant_fire),
        .push_id (w_grant_id),
        .pop     (w_pop),
        .head_id (w_head_id),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_bridge_req_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_bridge_req_arbiter
// Description : Self-checking bench for bridge_req_arbiter (N_REQ=4, REQ_W=8,
//               MAX_OUTST=4). Cycle table plus hand-written sequences.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_bridge_req_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           res_n;
    logic [N-1:0]   req_avail, req_taken;
    logic [N*W-1:0] req_data;
    logic           data_from_bridge_avail, data_from_bridge_taken;
    logic [W-1:0]   merged_request_bridge_to_buffer;
    logic           data_to_bridge_avail, data_to_bridge_taken;
    logic [W-1:0]   merged_request_buffer_to_bridge;
    logic [N-1:0]   resp_avail, resp_taken;
    logic [W-1:0]   resp_data;
    logic           err_orphan;

    always #5 clk = ~clk;

    bridge_req_arbiter #(.N_REQ(N), .REQ_W(W), .MAX_OUTST(4)) dut (
        .clk                             (clk),
        .res_n                           (res_n),
        .req_avail                       (req_avail),
        .req_taken                       (req_taken),
        .req_data                        (req_data),
        .data_from_bridge_avail          (data_from_bridge_avail),
        .data_from_bridge_taken          (data_from_bridge_taken),
        .merged_request_bridge_to_buffer (merged_request_bridge_to_buffer),
        .data_to_bridge_avail            (data_to_bridge_avail),
        .data_to_bridge_taken            (data_to_bridge_taken),
        .merged_request_buffer_to_bridge (merged_request_buffer_to_bridge),
        .resp_avail                      (resp_avail),
        .resp_taken                      (resp_taken),
        .resp_data                       (resp_data),
        .err_orphan                      (err_orphan)
    );

    typedef struct {
        logic         rn;
        logic [N-1:0] ra;
        logic [31:0]  rd;
        logic         dft;
        logic         dta;
        logic [W-1:0] rin;
        logic [N-1:0] rt;
        logic [N-1:0] e_tk;
        logic         e_dfa;
        logic [W-1:0] e_mq;
        logic         e_dtt;
        logic [N-1:0] e_rav;
        logic [W-1:0] e_rd;
        logic         e_err;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(
        input logic rn, input logic [N-1:0] ra, input logic [31:0] rd,
        input logic dft, input logic dta, input logic [W-1:0] rin,
        input logic [N-1:0] rt, input logic [N-1:0] e_tk, input logic e_dfa,
        input logic [W-1:0] e_mq, input logic e_dtt, input logic [N-1:0] e_rav,
        input logic [W-1:0] e_rd, input logic e_err);
        vec_t v;
        v.rn = rn; v.ra = ra; v.rd = rd; v.dft = dft; v.dta = dta;
        v.rin = rin; v.rt = rt; v.e_tk = e_tk; v.e_dfa = e_dfa; v.e_mq = e_mq;
        v.e_dtt = e_dtt; v.e_rav = e_rav; v.e_rd = e_rd; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string tag, input string sig,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s %s: got 0x%0h, want 0x%0h", tag, sig, act, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge, compare just after.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        res_n                           = v.rn;
        req_avail                       = v.ra;
        req_data                        = v.rd;
        data_from_bridge_taken          = v.dft;
        data_to_bridge_avail            = v.dta;
        merged_request_buffer_to_bridge = v.rin;
        resp_taken                      = v.rt;
        #1;
        chk(tag, "req_taken",  32'(req_taken),                       32'(v.e_tk));
        chk(tag, "dfb_avail",  32'(data_from_bridge_avail),          32'(v.e_dfa));
        chk(tag, "mreq_out",   32'(merged_request_bridge_to_buffer), 32'(v.e_mq));
        chk(tag, "dtb_taken",  32'(data_to_bridge_taken),            32'(v.e_dtt));
        chk(tag, "resp_avail", 32'(resp_avail),                      32'(v.e_rav));
        chk(tag, "resp_data",  32'(resp_data),                       32'(v.e_rd));
        chk(tag, "err_orphan", 32'(err_orphan),                      32'(v.e_err));
    endtask

    // A pending (un-taken) request must still be asserted next cycle.
    logic [N-1:0] prev_pend = '0;
    always @(posedge clk) begin
        if (res_n && (|prev_pend)) begin
            n_cmp++;
            if ((prev_pend & ~req_avail) != '0) begin
                n_bad++;
                $display("FAIL withdraw: req_avail 0x%0h, pending 0x%0h", req_avail, prev_pend);
            end
        end
        prev_pend <= res_n ? (req_avail & ~req_taken) : '0;
    end

    localparam logic [31:0] D = 32'h13121110;

    initial begin
        res_n = 1'b0; req_avail = '0; req_data = '0; data_from_bridge_taken = 1'b0;
        data_to_bridge_avail = 1'b0; merged_request_buffer_to_bridge = '0; resp_taken = '0;
        repeat (2) @(negedge clk);

        //            rn ra       rd          dft dta rin    rt        e_tk    dfa mq     dtt rav      rd     err
        // reset state
        tbl.push_back(mk(0, 4'b0000, 32'h0,    0, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'h00, 0, 4'b0000, 8'h00, 0));
        // single request 0xA5 -> response 0x5A
        tbl.push_back(mk(1, 4'b0001, 32'hA5,   0, 0, 8'h00, 4'b0000, 4'b0001, 0, 8'h00, 0, 4'b0000, 8'h00, 0));
        tbl.push_back(mk(1, 4'b0000, 32'hA5,   1, 0, 8'h00, 4'b0000, 4'b0000, 1, 8'hA5, 0, 4'b0000, 8'h00, 0));
        tbl.push_back(mk(1, 4'b0000, 32'hA5,   0, 1, 8'h5A, 4'b0000, 4'b0000, 0, 8'hA5, 1, 4'b0000, 8'h00, 0));
        tbl.push_back(mk(1, 4'b0000, 32'hA5,   0, 0, 8'h00, 4'b0001, 4'b0000, 0, 8'hA5, 0, 4'b0001, 8'h5A, 0));
        tbl.push_back(mk(1, 4'b0000, 32'hA5,   0, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'hA5, 0, 4'b0000, 8'h5A, 0));
        // round robin from ptr=1 with all requesting: 1,2,3,0
        tbl.push_back(mk(1, 4'b1111, D,        0, 0, 8'h00, 4'b0000, 4'b0010, 0, 8'hA5, 0, 4'b0000, 8'h5A, 0));
        tbl.push_back(mk(1, 4'b1101, D,        1, 0, 8'h00, 4'b0000, 4'b0000, 1, 8'h11, 0, 4'b0000, 8'h5A, 0));
        tbl.push_back(mk(1, 4'b1101, D,        0, 0, 8'h00, 4'b0000, 4'b0100, 0, 8'h11, 0, 4'b0000, 8'h5A, 0));
        tbl.push_back(mk(1, 4'b1001, D,        1, 0, 8'h00, 4'b0000, 4'b0000, 1, 8'h12, 0, 4'b0000, 8'h5A, 0));
        tbl.push_back(mk(1, 4'b1001, D,        0, 0, 8'h00, 4'b0000, 4'b1000, 0, 8'h12, 0, 4'b0000, 8'h5A, 0));
        tbl.push_back(mk(1, 4'b0001, D,        1, 0, 8'h00, 4'b0000, 4'b0000, 1, 8'h13, 0, 4'b0000, 8'h5A, 0));
        tbl.push_back(mk(1, 4'b0001, D,        0, 0, 8'h00, 4'b0000, 4'b0001, 0, 8'h13, 0, 4'b0000, 8'h5A, 0));
        // FIFO now full: further requests wait
        tbl.push_back(mk(1, 4'b0011, D,        1, 0, 8'h00, 4'b0000, 4'b0000, 1, 8'h10, 0, 4'b0000, 8'h5A, 0));
        tbl.push_back(mk(1, 4'b0011, D,        0, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'h10, 0, 4'b0000, 8'h5A, 0));
        tbl.push_back(mk(1, 4'b0011, D,        0, 1, 8'h77, 4'b0000, 4'b0000, 0, 8'h10, 1, 4'b0000, 8'h5A, 0));
        // wrong requester's taken ignored; owner (1) pops; grant only next cycle
        tbl.push_back(mk(1, 4'b0011, D,        0, 0, 8'h00, 4'b0001, 4'b0000, 0, 8'h10, 0, 4'b0010, 8'h77, 0));
        tbl.push_back(mk(1, 4'b0011, D,        0, 0, 8'h00, 4'b0010, 4'b0000, 0, 8'h10, 0, 4'b0010, 8'h77, 0));
        tbl.push_back(mk(1, 4'b0011, D,        0, 0, 8'h00, 4'b0000, 4'b0010, 0, 8'h10, 0, 4'b0000, 8'h77, 0));
        tbl.push_back(mk(1, 4'b0001, D,        1, 0, 8'h00, 4'b0000, 4'b0000, 1, 8'h11, 0, 4'b0000, 8'h77, 0));
        tbl.push_back(mk(1, 4'b0001, D,        0, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'h11, 0, 4'b0000, 8'h77, 0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        // Reset back to a clean state.
        apply(mk(0, 4'b0001, D, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'h11, 0, 4'b0000, 8'h77, 0), "rst_a");
        apply(mk(0, 4'b0000, 32'h0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'h00, 0, 4'b0000, 8'h00, 0), "rst_b");

        // Routing: requests from 2 then 0, responses 0x11 then 0x22.
        apply(mk(1, 4'b0100, 32'h00320030, 0, 0, 8'h00, 4'b0000, 4'b0100, 0, 8'h00, 0, 4'b0000, 8'h00, 0), "route_g2");
        apply(mk(1, 4'b0001, 32'h00320030, 1, 0, 8'h00, 4'b0000, 4'b0000, 1, 8'h32, 0, 4'b0000, 8'h00, 0), "route_s2");
        apply(mk(1, 4'b0001, 32'h00320030, 0, 0, 8'h00, 4'b0000, 4'b0001, 0, 8'h32, 0, 4'b0000, 8'h00, 0), "route_g0");
        apply(mk(1, 4'b0000, 32'h00320030, 1, 0, 8'h00, 4'b0000, 4'b0000, 1, 8'h30, 0, 4'b0000, 8'h00, 0), "route_s0");
        apply(mk(1, 4'b0000, 32'h0, 0, 1, 8'h11, 4'b0000, 4'b0000, 0, 8'h30, 1, 4'b0000, 8'h00, 0), "route_r1");
        apply(mk(1, 4'b0000, 32'h0, 0, 0, 8'h00, 4'b0100, 4'b0000, 0, 8'h30, 0, 4'b0100, 8'h11, 0), "route_h1");
        apply(mk(1, 4'b0000, 32'h0, 0, 1, 8'h22, 4'b0000, 4'b0000, 0, 8'h30, 1, 4'b0000, 8'h11, 0), "route_r2");
        apply(mk(1, 4'b0000, 32'h0, 0, 0, 8'h00, 4'b0001, 4'b0000, 0, 8'h30, 0, 4'b0001, 8'h22, 0), "route_h2");
        apply(mk(1, 4'b0000, 32'h0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'h30, 0, 4'b0000, 8'h22, 0), "route_end");

        // Orphan response: not consumed, sticky flag.
        apply(mk(1, 4'b0000, 32'h0, 0, 1, 8'h99, 4'b0000, 4'b0000, 0, 8'h30, 0, 4'b0000, 8'h22, 0), "orph_a");
        apply(mk(1, 4'b0000, 32'h0, 0, 1, 8'h99, 4'b0000, 4'b0000, 0, 8'h30, 0, 4'b0000, 8'h22, 1), "orph_b");
        apply(mk(1, 4'b0000, 32'h0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'h30, 0, 4'b0000, 8'h22, 1), "orph_c");

        // Reset while in R_SEND with two IDs outstanding (ptr=1 here).
        apply(mk(1, 4'b0100, 32'h00420040, 0, 0, 8'h00, 4'b0000, 4'b0100, 0, 8'h30, 0, 4'b0000, 8'h22, 1), "mid_g2");
        apply(mk(1, 4'b0001, 32'h00420040, 1, 0, 8'h00, 4'b0000, 4'b0000, 1, 8'h42, 0, 4'b0000, 8'h22, 1), "mid_s2");
        apply(mk(1, 4'b0001, 32'h00420040, 0, 0, 8'h00, 4'b0000, 4'b0001, 0, 8'h42, 0, 4'b0000, 8'h22, 1), "mid_g0");
        apply(mk(1, 4'b0000, 32'h00420040, 0, 0, 8'h00, 4'b0000, 4'b0000, 1, 8'h40, 0, 4'b0000, 8'h22, 1), "mid_send");
        apply(mk(0, 4'b0000, 32'h0, 0, 1, 8'h55, 4'b0000, 4'b0000, 1, 8'h40, 0, 4'b0000, 8'h22, 1), "mid_rst");
        apply(mk(0, 4'b1111, 32'h53525150, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'h00, 0, 4'b0000, 8'h00, 0), "mid_zero");
        apply(mk(1, 4'b1111, 32'h53525150, 0, 0, 8'h00, 4'b0000, 4'b0001, 0, 8'h00, 0, 4'b0000, 8'h00, 0), "post_g0");
        apply(mk(1, 4'b1110, 32'h53525150, 1, 0, 8'h00, 4'b0000, 4'b0000, 1, 8'h50, 0, 4'b0000, 8'h00, 0), "post_s0");
        apply(mk(1, 4'b1110, 32'h53525150, 0, 1, 8'h66, 4'b0000, 4'b0010, 0, 8'h50, 1, 4'b0000, 8'h00, 0), "post_g1");
        apply(mk(1, 4'b1100, 32'h53525150, 1, 0, 8'h00, 4'b0001, 4'b0000, 1, 8'h51, 0, 4'b0001, 8'h66, 0), "post_h0");
        apply(mk(1, 4'b1100, 32'h53525150, 0, 0, 8'h00, 4'b0000, 4'b0100, 0, 8'h51, 0, 4'b0000, 8'h66, 0), "post_g2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bridge_req_arbiter.md
Name: bridge_req_arbiter

Overview:
- Shares one flit buffer bridge-master port among N_REQ local requesters, e.g. core, DMA and debug.
- Request path: round-robin grant; the winner's merged request is registered and presented to the buffer's from-bridge channel.
- Response path: responses on the buffer's to-bridge channel are returned in order. Each goes to the requester recorded in an outstanding-ID FIFO.
- Sits between the requesters and flit_buffer; the NoC side is untouched.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- REQ_W, `MERGED_REQUEST_WIDTH, merged request/response width.
- MAX_OUTST, 4, outstanding-ID FIFO depth (power of two).
- ID_W, $clog2(N_REQ), requester ID width (derived, not overridable).

Ports:
- clk  in  1  clock.
- res_n  in  1  synchronous active-low reset.
- req_avail  in  N_REQ  requester i holds a request.
- req_taken  out  N_REQ  one-hot pulse: request i accepted.
- req_data  in  N_REQ*REQ_W  requests; slice i = [i*REQ_W +: REQ_W].
- data_from_bridge_avail  out  1  request valid to buffer.
- data_from_bridge_taken  in  1  buffer accepted request.
- merged_request_bridge_to_buffer  out  REQ_W  registered granted request.
- data_to_bridge_avail  in  1  buffer holds a response.
- data_to_bridge_taken  out  1  pulse: response consumed.
- merged_request_buffer_to_bridge  in  REQ_W  response from buffer.
- resp_avail  out  N_REQ  one-hot: response ready for requester i.
- resp_taken  in  N_REQ  requester i accepts response.
- resp_data  out  REQ_W  registered response, shared by all requesters.
- err_orphan  out  1  sticky: response arrived with no outstanding ID.

Behaviour:
- Handshakes: a transfer occurs in any cycle with avail=1 and taken=1. A source holds avail and data stable until transfer. taken is asserted only while avail=1.
- Reset values (res_n=0 at posedge): all outputs 0, rr_ptr=0, both FSMs idle, FIFO empty, err_orphan=0. Reset mid-transaction drops in-flight request/response and all IDs; no pulse is issued in that cycle.
- Request FSM states:
  - R_IDLE: if any req_avail and FIFO not full, grant g = first set bit of req_avail searching from rr_ptr upward, wrapping at N_REQ.
  - In the grant cycle: req_taken[g]=1 (combinational pulse), latch req_data[g] into merged_request_bridge_to_buffer, push g, go to R_SEND.
  - FIFO full: no grant, req_taken=0.
  - R_SEND: data_from_bridge_avail=1. On data_from_bridge_taken: rr_ptr = (g+1) mod N_REQ, go to R_IDLE. Avail deasserts the following cycle.
  - Throughput: at most one request per 2 cycles. Grant-to-buffer-avail latency is 1 cycle.
- Response FSM states:
  - S_IDLE: if data_to_bridge_avail and FIFO not empty: data_to_bridge_taken=1 (combinational), latch response into resp_data, latch head ID h, go to S_HOLD.
  - S_IDLE, data_to_bridge_avail with FIFO empty: do not take; set err_orphan. The response stays pending in the buffer.
  - S_HOLD: resp_avail[h]=1. On resp_taken[h]: pop FIFO, go to S_IDLE. resp_taken of other bits is ignored.
- FIFO:
  - Push and pop in the same cycle are both performed; count is unchanged, and this is legal even when full.
  - The full check for a grant uses the registered count. A pop in the same cycle does not enable a grant.
  - Pointers wrap modulo MAX_OUTST. Count is $clog2(MAX_OUTST)+1 bits.
- Ordering: responses are assumed in request order (the NoC path is in-order per node). No reordering is performed.
- A requester whose request is pending may deassert nothing. Request withdrawal is illegal; the bench asserts on it.

Decomposition:
- Shared package bridge_arb_pkg:
  - req_id_t (logic [ID_W-1:0]).
  - Request FSM enum (R_IDLE, R_SEND) and response FSM enum (S_IDLE, S_HOLD).
  - Function rr_pick(req_vec, ptr) returning the one-hot grant.
- One natural sub-module: bridge_id_fifo (MAX_OUTST x ID_W, push/pop/full/empty/count), synchronous active-low reset.

Test Plan:
- Single request: req_avail=0001 with data 0xA5; buffer takes the cycle after avail.
  - req_taken=0001 in cycle 0; data_from_bridge_avail=1 with data 0xA5 in cycle 1.
  - Buffer returns 0x5A: resp_avail=0001, resp_data=0x5A.
- Round-robin: req_avail=1111 held and the buffer always takes; grant order 0,1,2,3,0. Each requester is taken once per 8 cycles.
- Backpressure: MAX_OUTST=4 with no responses; after 4 grants the 5th req_avail stays un-taken.
  - One response is delivered and resp_taken, which pops the FIFO.
  - The next grant occurs on the cycle after the pop.
- Routing: requests from 2 then 0; responses 0x11 then 0x22. Expect resp_avail=0100 with 0x11, then 0001 with 0x22.
- Orphan: data_to_bridge_avail=1 with FIFO empty → data_to_bridge_taken stays 0, err_orphan=1 until reset.
- Reset mid-op: res_n=0 while in R_SEND with 2 IDs outstanding.
  - Next cycle: all outputs 0, FIFO empty, rr_ptr=0.
  - First grant after reset goes to requester 0.
